// File: rtl/parallel_to_serial_pkg.sv
// Shared constants, word record, length decode and FSM encoding for the
// parallel-to-serial transmitter (and its matching receiver).
package parallel_to_serial_pkg;

  localparam int P2S_DATA_W = 32;
  localparam int P2S_LEN_W  = 5;
  localparam int P2S_CNT_W  = P2S_LEN_W + 1;

  typedef enum logic {
    P2S_IDLE  = 1'b0,
    P2S_SHIFT = 1'b1
  } p2s_state_e;

  typedef struct packed {
    logic [P2S_DATA_W-1:0] data;
    logic [P2S_LEN_W-1:0]  width;
  } p2s_word_t;

  // A width field of zero encodes a full 32-bit word.
  function automatic logic [P2S_CNT_W-1:0] len_of(input logic [P2S_LEN_W-1:0] width);
    return (width == '0) ? P2S_CNT_W'(P2S_DATA_W) : {1'b0, width};
  endfunction

endpackage

// File: rtl/p2s_hold_buffer.sv
// Single-entry ready/valid register slice holding one pending word while the
// shifter is busy with the current one.
module p2s_hold_buffer
  import parallel_to_serial_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      in_valid,
  output logic      in_ready,
  input  p2s_word_t in_word,
  output logic      out_valid,
  output p2s_word_t out_word,
  input  logic      out_ready
);

  logic      full_q, full_d;
  p2s_word_t word_q, word_d;

  always_comb begin
    full_d = full_q;
    word_d = word_q;
    // Push and pop are mutually exclusive: push needs empty, pop needs full.
    if (in_valid && !full_q) begin
      full_d = 1'b1;
      word_d = in_word;
    end else if (out_ready && full_q) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
      word_q <= '0;
    end else begin
      full_q <= full_d;
      word_q <= word_d;
    end
  end

  assign in_ready  = !full_q;
  assign out_valid = full_q;
  assign out_word  = word_q;

endmodule

// File: rtl/parallel_to_serial.sv
// LSB-first serializer: loads 32-bit words with a per-word length and emits one
// bit per clock, chaining a held word into the shifter with no idle cycle.
module parallel_to_serial
  import parallel_to_serial_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [P2S_DATA_W-1:0] load_data,
  input  logic [P2S_LEN_W-1:0]  load_width,
  output logic                  out,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  word_done
);

  p2s_state_e            state_q, state_d;
  logic [P2S_DATA_W-1:0] shreg_q, shreg_d;
  logic [P2S_CNT_W-1:0]  cnt_q, cnt_d;
  logic [P2S_CNT_W-1:0]  len_q, len_d;
  logic                  word_done_q, word_done_d;

  logic      accept;
  logic      last_bit;
  logic      hold_push;
  logic      hold_pop;
  logic      hold_ready;
  logic      hold_full;
  p2s_word_t hold_word;
  p2s_word_t in_word;

  assign in_word    = '{data: load_data, width: load_width};
  assign load_ready = hold_ready;
  assign accept     = load_valid && load_ready;
  assign last_bit   = (state_q == P2S_SHIFT) && (cnt_q == len_q - P2S_CNT_W'(1));

  // Only words arriving mid-word park in the buffer; on the last-bit edge an
  // incoming word goes straight to the shifter instead.
  assign hold_push = accept && (state_q == P2S_SHIFT) && !last_bit;
  assign hold_pop  = last_bit && hold_full;

  p2s_hold_buffer u_hold (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (hold_push),
    .in_ready  (hold_ready),
    .in_word   (in_word),
    .out_valid (hold_full),
    .out_word  (hold_word),
    .out_ready (hold_pop)
  );

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    word_done_d = last_bit;

    unique case (state_q)
      P2S_IDLE: begin
        if (accept) begin
          state_d = P2S_SHIFT;
          shreg_d = load_data;
          cnt_d   = '0;
          len_d   = len_of(load_width);
        end
      end
      P2S_SHIFT: begin
        if (last_bit) begin
          if (hold_full) begin
            shreg_d = hold_word.data;
            cnt_d   = '0;
            len_d   = len_of(hold_word.width);
          end else if (accept) begin
            shreg_d = load_data;
            cnt_d   = '0;
            len_d   = len_of(load_width);
          end else begin
            state_d = P2S_IDLE;
            shreg_d = '0;
            cnt_d   = '0;
            len_d   = '0;
          end
        end else begin
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + P2S_CNT_W'(1);
        end
      end
      default: state_d = P2S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= P2S_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      word_done_q <= word_done_d;
    end
  end

  // Shifter bit 0 is the line; it is cleared whenever the FSM idles.
  assign out       = shreg_q[0];
  assign out_valid = (state_q == P2S_SHIFT);
  assign out_last  = last_bit;
  assign word_done = word_done_q;

endmodule

// File: doc/parallel_to_serial.md
Name: parallel_to_serial

Overview:
Transmit-side counterpart of the serial-to-parallel capture block. Accepts 32-bit parallel words with a per-word bit length over a ready/valid load port, then emits them LSB-first, one bit per clock, on a single-bit line. Bit order and the length encoding match the receiver, so bit i of a loaded word reaches the receiver's bits[i]. A one-word holding buffer allows back-to-back words with no idle cycle between them.

Parameters:
- none. Data width is fixed at 32 and the length field at 5 bits, matching the receiver.

Ports:
- clock       input   1   rising-edge clock
- reset       input   1   asynchronous, active-high reset
- load_valid  input   1   load_data / load_width are valid this cycle
- load_ready  output  1   block can accept a word; equal to !hold_full
- load_data   input   32  word to send; bit 0 goes out first
- load_width  input   5   bit count of the word; 1..31 literal, 0 means 32
- out         output  1   serial bit, registered
- out_valid   output  1   out carries a payload bit this cycle
- out_last    output  1   this cycle carries the final bit of the word
- word_done   output  1   one-cycle pulse in the cycle after a word's last bit

Behaviour:
- Reset state: out=0, out_valid=0, out_last=0, word_done=0, load_ready=1. Shifter, counter and holding buffer are empty. FSM is IDLE.
- Reset asserted mid-word aborts the word and discards any held word. No word_done is produced for the aborted word.
- Accept: a word is accepted on a rising edge where load_valid && load_ready. load_data and load_width are sampled together. Changing load_width later never affects a word already accepted.
- Length rule: len = (load_width == 0) ? 32 : load_width. Store it as 6 bits internally.
- FSM states:
  - IDLE: shifter empty.
  - SHIFT: emitting bits; cnt counts 0..len-1.
- IDLE with holding buffer empty and an accepted word: the word loads straight into the shifter with cnt=0 and the FSM enters SHIFT. Latency is 1: bit 0 appears on out, with out_valid=1, in the cycle after the accept edge.
- SHIFT, each edge:
  - out advances to the next bit (shift right) and cnt increments.
  - out_last = out_valid && (cnt == len-1).
- Last-bit edge (the edge ending the out_last cycle):
  - If the holding buffer is full, or a word is accepted on this same edge with the buffer empty, that word loads into the shifter with cnt=0. The FSM stays in SHIFT, so there is no gap.
  - A held word takes priority. While the buffer is full, load_ready=0, so no new word can arrive on that edge.
  - Otherwise the FSM goes to IDLE, out_valid=0 and out=0.
- Accept during SHIFT, not on the last-bit edge: the word goes into the holding buffer, hold_full=1 and load_ready drops in the next cycle.
- word_done: registered. High for exactly one cycle after every out_last cycle, including back-to-back words. This mirrors the receiver's need_store timing.
- Width 1: out_last=1 in the word's only cycle. A stream of width-1 words produces out_last=1 continuously and word_done=1 continuously, one cycle delayed.
- The receiver samples every clock and has no qualifier. Upstream logic must keep out_valid continuous during a transfer; this block never inserts gaps in the middle of a word.

Decomposition:
- Shared package constants:
  - P2S_DATA_W = 32
  - P2S_LEN_W = 5
  - the function len_of(width) implementing the 0-means-32 rule, shared with the receiver and its bench.
  - FSM state encoding (IDLE/SHIFT).
- One natural sub-module: p2s_hold_buffer, a single-entry ready/valid register slice holding data and width. The shifter and FSM stay in the top module.

Test Plan:
- Single word: after reset, load 0x0000_00B5 with width 8 → out sequence 1,0,1,0,1,1,0,1 on cycles 1..8 after accept; out_last on cycle 8; word_done on cycle 9; out_valid=0 on cycle 9.
- Width 0: load 0x8000_0001 with width 0 → 32 valid cycles; out=1 on the first and 32nd bits, 0 otherwise; out_last only on the 32nd cycle.
- Back-to-back: load A=0x3 (w=2), then immediately B=0x5 (w=3) while A is shifting → out 1,1,1,0,1 with no gap; load_ready low while B is held; word_done on cycles 3 and 6.
- Width-1 stream: load_valid held high with alternating data 1/0, w=1 → out 1,0,1,0…; out_last constant 1; word_done constant 1 from the second cycle.
- Reset mid-word: load 0xFF (w=8), assert reset after 3 bits with a word held → all outputs 0 immediately (asynchronous), no word_done, load_ready=1; the next load starts cleanly at bit 0.
- Loopback: connect to the receiver (its active-low reset driven by !reset) and send random data and width → the receiver's bits equal load_data masked to len on every need_store.
